// File: rtl/instr_mem_loader.sv
// ============================================================================
// Module   : instr_mem_loader
// Purpose  : Streams 32-bit words into a byte-wide instruction memory, MSB first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_mem_loader #(
    parameter int ADDR_W = 5,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       word_in,
    input  logic              word_valid,
    input  logic              word_last,
    output logic              word_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   byte_count
);

    localparam logic [ADDR_W:0] c_CAP_BYTES = (ADDR_W+1)'(WORDS * 4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_base;
    logic [1:0]        r_bidx;
    logic [31:0]       r_word;
    logic              r_last;
    logic [ADDR_W:0]   r_byte_count;
    logic              r_overflow;

    logic              w_start_ok;
    logic              w_accept;
    logic              w_word_end;
    logic [ADDR_W:0]   w_count_inc;
    logic              w_cap_hit;

    assign w_start_ok  = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    assign w_accept    = (r_state == S_LOAD) && word_valid;
    assign w_word_end  = (r_state == S_WRITE) && (r_bidx == 2'd3);
    assign w_count_inc = r_byte_count + 1'b1;
    assign w_cap_hit   = (w_count_inc == c_CAP_BYTES);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The held last flag wins over capacity, so a final 8th word is not an overflow.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE,
            S_DONE:  if (start)      w_next_state = S_LOAD;
            S_LOAD:  if (word_valid) w_next_state = S_WRITE;
            S_WRITE: begin
                if (r_bidx == 2'd3) begin
                    if (r_last)         w_next_state = S_DONE;
                    else if (w_cap_hit) w_next_state = S_DONE;
                    else                w_next_state = S_LOAD;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base       <= '0;
            r_bidx       <= 2'd0;
            r_word       <= 32'd0;
            r_last       <= 1'b0;
            r_byte_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_base       <= '0;
                r_byte_count <= '0;
                r_overflow   <= 1'b0;
            end
            if (w_accept) begin
                r_word <= word_in;
                r_last <= word_last;
                r_bidx <= 2'd0;
            end
            if (r_state == S_WRITE) begin
                r_byte_count <= w_count_inc;
                r_bidx       <= r_bidx + 2'd1;
            end
            if (w_word_end) begin
                r_base <= r_base + ADDR_W'(4);
                if (!r_last && w_cap_hit) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // Address and data are forced to zero outside WRITE so the memory port idles cleanly.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = 8'd0;
        if (r_state == S_WRITE) begin
            mem_addr = r_base + ADDR_W'(r_bidx);
            case (r_bidx)
                2'd0:    mem_wdata = r_word[31:24];
                2'd1:    mem_wdata = r_word[23:16];
                2'd2:    mem_wdata = r_word[15:8];
                default: mem_wdata = r_word[7:0];
            endcase
        end
    end

    assign word_ready = (r_state == S_LOAD);
    assign mem_we     = (r_state == S_WRITE);
    assign busy       = (r_state == S_LOAD) || (r_state == S_WRITE);
    assign done       = (r_state == S_DONE);
    assign overflow   = r_overflow;
    assign byte_count = r_byte_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// ============================================================================
// Module   : tb_instr_mem_loader
// Purpose  : Directed self-checking bench for instr_mem_loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_mem_loader;

    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       word_in = 32'd0;
    logic              word_valid = 1'b0;
    logic              word_last = 1'b0;
    logic              word_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W:0]   byte_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          nwords;
        logic [31:0] base_word;
        bit          last_final;
        int          exp_count;
        bit          exp_ovf;
    } sess_t;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] mem [32];

    instr_mem_loader #(.ADDR_W(ADDR_W), .WORDS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_last  (word_last),
        .word_ready (word_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction memory model plus write scoreboard.
    always @(negedge clk) begin
        if (rst && mem_we) begin
            mem[mem_addr] = mem_wdata;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.a));
                check("wr_data", 32'(mem_wdata), 32'(e.d));
            end
        end
    end

    task automatic push_word(input int idx, input logic [31:0] w);
        wr_t e;
        for (int b = 0; b < 4; b++) begin
            e.a = ADDR_W'(idx * 4 + b);
            e.d = w[31 - 8*b -: 8];
            exp_q.push_back(e);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, 32'(word_ready), 0);
        check({tag, "_we"},    32'(mem_we), 0);
        check({tag, "_addr"},  32'(mem_addr), 0);
        check({tag, "_wdata"}, 32'(mem_wdata), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_ovf"},   32'(overflow), 0);
        check({tag, "_count"}, 32'(byte_count), 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ready", 32'(word_ready), 1);
        check("start_count", 32'(byte_count), 0);
        check("start_done",  32'(done), 0);
        check("start_ovf",   32'(overflow), 0);
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 1;
        while (!word_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic wait_done(output int cnt);
        cnt = 1;
        while (!done && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic run_session(input sess_t s);
        int          acc;
        int          cnt;
        logic [31:0] w;
        logic [31:0] f;
        acc = s.last_final ? s.nwords : ((s.nwords > 8) ? 8 : s.nwords);
        do_start();
        for (int i = 0; i < acc; i++) begin
            w          = s.base_word + 32'(i) * 32'h10101010;
            word_in    = w;
            word_last  = s.last_final && (i == acc - 1);
            word_valid = 1'b1;
            push_word(i, w);
            @(negedge clk);
            if (i < acc - 1) begin
                wait_ready(cnt);
                check("ready_gap", 32'(cnt), 5);
            end
        end
        word_last = 1'b0;
        if (s.nwords > acc) begin
            word_in    = s.base_word + 32'(acc) * 32'h10101010;
            word_valid = 1'b1;
        end else begin
            word_valid = 1'b0;
        end
        wait_done(cnt);
        check("done_latency",  32'(cnt), 5);
        check("sess_done",     32'(done), 1);
        check("sess_busy",     32'(busy), 0);
        check("sess_ovf",      32'(overflow), 32'(s.exp_ovf));
        check("sess_count",    32'(byte_count), 32'(s.exp_count));
        check("writes_pending", 32'(exp_q.size()), 0);
        if (s.nwords > acc) begin
            repeat (5) begin
                @(negedge clk);
                check("ready_after_ovf", 32'(word_ready), 0);
            end
            word_valid = 1'b0;
        end
        if (s.last_final) begin
            for (int i = 0; i < acc; i++) begin
                f = {mem[4*i], mem[4*i+1], mem[4*i+2], mem[4*i+3]};
                check("fetch", f, s.base_word + 32'(i) * 32'h10101010);
            end
        end
    endtask

    sess_t sess [3];

    initial begin
        int cnt;
        bit found;

        sess[0] = '{nwords: 1, base_word: 32'hFC200008, last_final: 1'b1, exp_count: 4,  exp_ovf: 1'b0};
        sess[1] = '{nwords: 7, base_word: 32'h00A00093, last_final: 1'b1, exp_count: 28, exp_ovf: 1'b0};
        sess[2] = '{nwords: 9, base_word: 32'h12345678, last_final: 1'b0, exp_count: 32, exp_ovf: 1'b1};

        repeat (2) @(negedge clk);
        check_zero("por");
        rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            run_session(sess[k]);
            @(negedge clk);
        end

        // Mid-cycle reset from DONE with overflow set.
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // start and word_valid activity during WRITE must not disturb the sequence.
        do_start();
        word_in    = 32'hA1B2C3D4;
        word_last  = 1'b0;
        word_valid = 1'b1;
        push_word(0, 32'hA1B2C3D4);
        @(negedge clk);
        word_valid = 1'b0;
        start      = 1'b1;
        word_in    = 32'hDEADBEEF;
        @(negedge clk);
        start      = 1'b0;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        @(negedge clk);
        word_valid = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("toggle_ready", 32'(word_ready), 1);
        word_in    = 32'h0F1E2D3C;
        word_last  = 1'b1;
        word_valid = 1'b1;
        push_word(1, 32'h0F1E2D3C);
        @(negedge clk);
        word_valid = 1'b0;
        word_last  = 1'b0;
        wait_done(cnt);
        check("toggle_done_lat", 32'(cnt), 5);
        check("toggle_count",    32'(byte_count), 8);
        check("toggle_ovf",      32'(overflow), 0);
        check("toggle_pending",  32'(exp_q.size()), 0);
        @(negedge clk);
        do_start();
        word_in    = 32'h55AA0FF0;
        word_last  = 1'b1;
        word_valid = 1'b1;
        push_word(0, 32'h55AA0FF0);
        @(negedge clk);
        word_valid = 1'b0;
        word_last  = 1'b0;
        wait_done(cnt);
        check("restart_count", 32'(byte_count), 4);
        check("restart_pending", 32'(exp_q.size()), 0);

        // Reset during the third byte of the second word.
        @(negedge clk);
        do_start();
        word_in    = 32'h11223344;
        word_valid = 1'b1;
        push_word(0, 32'h11223344);
        @(negedge clk);
        wait_ready(cnt);
        word_in = 32'h55667788;
        push_word(1, 32'h55667788);
        @(negedge clk);
        word_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (mem_we && mem_addr == ADDR_W'(6)) found = 1'b1;
            else @(negedge clk);
        end
        check("found_addr6", 32'(found), 1);
        #2 rst = 1'b0;
        #1 check_zero("rst_mid_write");
        exp_q.delete();
        @(negedge clk);
        check("rst_hold_we", 32'(mem_we), 0);
        rst = 1'b1;
        @(negedge clk);
        do_start();
        word_in    = 32'h99AABBCC;
        word_last  = 1'b1;
        word_valid = 1'b1;
        push_word(0, 32'h99AABBCC);
        @(negedge clk);
        word_valid = 1'b0;
        word_last  = 1'b0;
        wait_done(cnt);
        check("post_rst_done",  32'(done), 1);
        check("post_rst_count", 32'(byte_count), 4);
        check("post_rst_pending", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/instr_mem_loader.md
# instr_mem_loader

Write-side companion to the byte-addressed instruction memory: accepts 32-bit instruction words over a valid/ready stream and writes them into the 32-byte memory's byte write port, one byte per cycle.

- Byte order is big-endian, so a fetch at `PC` returns `{mem[PC], mem[PC+1], mem[PC+2], mem[PC+3]}` as the original word.
- Sits between the boot/test source and the instruction memory.
- Runs while the core is held off; signals completion and capacity overflow.

## Interface
- `ADDR_W`, 5, byte address width; memory depth is 2^ADDR_W bytes (32).
- `WORDS`, 8, word capacity, 2^ADDR_W / 4.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a load session from address 0; honoured only in IDLE or DONE.
- `word_in`  in  32  instruction word.
- `word_valid`  in  1  `word_in` is valid.
- `word_last`  in  1  qualifies `word_in` as the final word of the session.
- `word_ready`  out  1  loader can accept a word this cycle.
- `mem_we`  out  1  byte write enable to instruction memory.
- `mem_addr`  out  ADDR_W  byte write address.
- `mem_wdata`  out  8  byte write data.
- `busy`  out  1  session in progress (LOAD or WRITE).
- `done`  out  1  session finished; held until the next `start` or reset.
- `overflow`  out  1  capacity exhausted before `word_last`; held with `done`.
- `byte_count`  out  ADDR_W+1  bytes written this session (0..32).

## Operation
- States:
  - IDLE: reset state.
  - LOAD: waiting for a word.
  - WRITE: 4 byte cycles, indexed by a 2-bit byte counter `bidx`.
  - DONE: session finished.
- IDLE/DONE --`start`--> LOAD. Entering LOAD from `start` clears the base address, `byte_count`, `done` and `overflow`.
- LOAD: `word_ready`=1. A handshake (`word_valid` & `word_ready`) captures `word_in` and `word_last` into holding registers, then moves to WRITE with `bidx`=0.
- WRITE, per cycle:
  - `mem_we`=1.
  - `mem_addr` = base + `bidx`.
  - `mem_wdata` = held word byte: `bidx` 0 → [31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0].
  - `byte_count` increments.
- After `bidx`=3, the base advances by 4. The next state is decided in this order:
  - DONE with `overflow`=0 if the held `last` flag is set.
  - DONE with `overflow`=1 if `byte_count` reached 32.
  - LOAD otherwise.
- `last` is checked before capacity: an 8th word carrying `word_last` ends with `overflow`=0.
- `word_ready`=0 in IDLE, WRITE and DONE. No word is accepted after overflow.
- `start` in LOAD or WRITE is ignored. The session is not restarted.
- `word_valid` outside LOAD has no effect. The source must hold the word until `word_ready`.
- Address arithmetic is unsigned modulo 2^ADDR_W. The internal base never wraps during a session, because DONE is entered at 32 bytes.
- `busy` = (state is LOAD or WRITE).

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- Reset (asynchronous, `rst`=0), immediately:
  - state is IDLE.
  - `word_ready`, `mem_we`, `busy`, `done` and `overflow` are 0.
  - `mem_addr`=0, `mem_wdata`=0, `byte_count`=0.
- Reset mid-WRITE aborts the session at once. Bytes already written stay in memory. No further `mem_we` occurs.
- Handshake at edge N puts the first byte write (`mem_we`=1) in cycle N+1, and the 4th byte in cycle N+4.
- `word_ready` reasserts in cycle N+5 (back in LOAD), or `done` asserts in cycle N+5.
- Sustained throughput is 1 word per 5 cycles.
- `start` sampled at edge S gives `word_ready`=1 in cycle S+1.
- `done` rises in the same cycle `busy` falls.

## Test plan
- Reset check: assert `rst`=0 mid-clock → all outputs 0 immediately, with no clock edge needed.
- Single word, `word_last`=1, `word_in`=32'hFC200008 after `start` → 4 consecutive writes, then `done`=1, `overflow`=0, `byte_count`=4:
  - addr 0 ← FC
  - addr 1 ← 20
  - addr 2 ← 00
  - addr 3 ← 08
- Seven words with `word_valid` held high, last on word 7 → 28 writes at addresses 0..27 in big-endian order.
  - `word_ready` pulses every 5 cycles.
  - Then `done`=1, `overflow`=0, `byte_count`=28.
  - A read-back through the instruction memory fetch at PC=0,4,…,24 returns the original words.
- Nine words, none marked last → the 8th word completes at addr 31, then `done`=1, `overflow`=1, `byte_count`=32.
  - `word_ready` stays 0 and the 9th word is never accepted.
- `start` pulsed during WRITE and `word_valid` toggled during WRITE → no effect on address or data sequence.
  - Then a fresh `start` from DONE clears `done`, `overflow` and `byte_count`, and the next write lands at addr 0.
- `rst` asserted during the 3rd byte of word 2 (addr 6) → `mem_we` drops immediately, state is IDLE.
  - After release, `start` plus one word writes addresses 0..3.
